// File: rtl/sonar_pkg.sv
// Shared SonarOnChip constants and arithmetic helpers used by both the PDM
// transmit modulator and the receive-side decimation filters.
package sonar_pkg;

  localparam int PDM_DATA_W = 16;
  localparam int PDM_ACC_W  = 20;
  localparam int PDM_FB_POS = (32'sd1 <<< (PDM_DATA_W - 1)) - 32'sd1;
  localparam int PDM_FB_NEG = -(32'sd1 <<< (PDM_DATA_W - 1));

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_clamp = hi;
    end else if (v < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = v;
    end
  endfunction

endpackage

// File: rtl/pdm_modulator_sat_add.sv
// Signed W-bit a + b - sub with clamping; one instance per sigma-delta integrator.
module sat_add
  import sonar_pkg::*;
#(
  parameter int W = PDM_ACC_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_sub,
  output logic [W-1:0] o_sum
);

  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [63:0] w_sub;

  assign w_a   = {{(64 - W){i_a[W-1]}}, i_a};
  assign w_b   = {{(64 - W){i_b[W-1]}}, i_b};
  assign w_sub = {{(64 - W){i_sub[W-1]}}, i_sub};

  // The 64-bit sum cannot overflow for any legal W, so clamping it is exact.
  assign o_sum = W'(sat_clamp(signed'(w_a) + signed'(w_b) - signed'(w_sub), W));

endmodule

// File: rtl/pdm_modulator.sv
// Second-order sigma-delta PDM modulator: one-entry PCM input buffer, two
// saturating integrators and a registered 1-bit quantiser output.
module pdm_modulator
  import sonar_pkg::*;
#(
  parameter int DATA_W = PDM_DATA_W,
  parameter int ACC_W  = PDM_ACC_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ce_pdm,
  input  logic              ce_pcm,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] pcm_dat_i,
  input  logic              pcm_valid_i,
  output logic              pcm_ready_o,
  output logic              pdm_data_o,
  output logic              underrun_o
);

  localparam int FB_POS_I = (DATA_W == PDM_DATA_W) ? PDM_FB_POS : ((32'sd1 <<< (DATA_W - 1)) - 32'sd1);
  localparam int FB_NEG_I = (DATA_W == PDM_DATA_W) ? PDM_FB_NEG : -(32'sd1 <<< (DATA_W - 1));
  localparam logic [ACC_W-1:0] FB_POS = ACC_W'(FB_POS_I);
  localparam logic [ACC_W-1:0] FB_NEG = ACC_W'(FB_NEG_I);

  logic              r_buf_full;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_cur;
  logic [ACC_W-1:0]  r_i1;
  logic [ACC_W-1:0]  r_i2;
  logic              r_pdm;
  logic              r_underrun;

  logic [ACC_W-1:0]  w_fb;
  logic [ACC_W-1:0]  w_cur_ext;
  logic [ACC_W-1:0]  w_i1n;
  logic [ACC_W-1:0]  w_i2n;
  logic              w_accept;
  logic              w_starve;

  assign pcm_ready_o = enable_i && !r_buf_full;
  assign w_accept    = pcm_valid_i && pcm_ready_o;
  assign w_starve    = ce_pcm && !r_buf_full && !w_accept;
  assign w_fb        = r_pdm ? FB_POS : FB_NEG;
  assign w_cur_ext   = {{(ACC_W - DATA_W){r_cur[DATA_W-1]}}, r_cur};
  assign pdm_data_o  = r_pdm;
  assign underrun_o  = r_underrun;

  sat_add #(.W(ACC_W)) u_sat_i1 (.i_a(r_i1), .i_b(w_cur_ext), .i_sub(w_fb), .o_sum(w_i1n));
  sat_add #(.W(ACC_W)) u_sat_i2 (.i_a(r_i2), .i_b(w_i1n),     .i_sub(w_fb), .o_sum(w_i2n));

  // Buffer, current sample, integrators, quantiser and underrun flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_cur      <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_pdm      <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!enable_i) begin
      // Idle: drop pending data, park the loop, emit a zero-mean toggle.
      r_buf_full <= 1'b0;
      r_cur      <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      if (ce_pdm) r_pdm <= !r_pdm;
      if (clear_i) r_underrun <= 1'b0;
    end else begin
      if (ce_pcm) begin
        if (r_buf_full) begin
          r_cur <= r_buf;
          if (w_accept) r_buf <= pcm_dat_i;
          else r_buf_full <= 1'b0;
        end else if (w_accept) begin
          r_cur <= pcm_dat_i;
        end
      end else if (w_accept) begin
        r_buf      <= pcm_dat_i;
        r_buf_full <= 1'b1;
      end

      if (w_starve) r_underrun <= 1'b1;
      else if (clear_i) r_underrun <= 1'b0;

      // The loop sees the pre-update cur when both strobes coincide.
      if (ce_pdm) begin
        r_i1  <= w_i1n;
        r_i2  <= w_i2n;
        r_pdm <= !w_i2n[ACC_W-1];
      end
    end
  end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: idle toggle, hand-computed first bits,
// mid-stream reset replay, density table and buffer/underrun handling.
module tb_pdm_modulator;

  logic        clk;
  logic        rst;
  logic        ce_pdm;
  logic        ce_pcm;
  logic        enable;
  logic        clear;
  logic [15:0] pcm_dat;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        pdm_data;
  logic        underrun;

  int n_err;
  int n_checks;

  typedef struct {
    logic [15:0] sample;
    int          settle;
    int          n;
    int          lo;
    int          hi;
    bit          chk_i2;
    int          exp_i2;
  } row_t;

  row_t rows [5];

  pdm_modulator dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .ce_pdm     (ce_pdm),
    .ce_pcm     (ce_pcm),
    .enable_i   (enable),
    .clear_i    (clear),
    .pcm_dat_i  (pcm_dat),
    .pcm_valid_i(pcm_valid),
    .pcm_ready_o(pcm_ready),
    .pdm_data_o (pdm_data),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic strobe(input logic pdm, input logic pcm);
    ce_pdm = pdm;
    ce_pcm = pcm;
    cyc();
    ce_pdm = 1'b0;
    ce_pcm = 1'b0;
  endtask

  task automatic run_strobes(input int n, output int ones);
    ones = 0;
    for (int k = 0; k < n; k++) begin
      strobe(1'b1, (k % 8) == 0);
      ones += int'(pdm_data);
      repeat (3) cyc();
    end
  endtask

  // From zero state: sample 16384 buffered, first ce_pdm coincides with ce_pcm
  // (loop still sees cur = 0), then seven more strobes on x = 16384.
  task automatic first_bits(input string tag);
    logic [7:0] exp_bits;
    exp_bits  = 8'b1011_0111;
    enable    = 1'b1;
    pcm_valid = 1'b1;
    pcm_dat   = 16'h4000;
    cyc();
    for (int k = 0; k < 8; k++) begin
      strobe(1'b1, k == 0);
      check(tag, int'(pdm_data), int'(exp_bits[k]));
      repeat (3) cyc();
    end
  endtask

  initial begin
    int ones;
    n_err     = 0;
    n_checks  = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    ce_pdm    = 1'b0;
    ce_pcm    = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    pcm_dat   = 16'h0000;
    pcm_valid = 1'b0;

    rows[0] = '{16'h0000, 32, 1024, 508, 516, 1'b0, 0};
    rows[1] = '{16'h4000, 32, 1024, 764, 772, 1'b0, 0};
    rows[2] = '{16'hC000, 32, 1024, 252, 260, 1'b0, 0};
    rows[3] = '{16'h7FFF, 48, 4096, 4090, 4096, 1'b1, 524287};
    rows[4] = '{16'h8000, 64, 1024, 0, 6, 1'b1, -524288};

    repeat (2) cyc();
    check("reset_pdm", int'(pdm_data), 0);
    check("reset_underrun", int'(underrun), 0);
    check("reset_ready", int'(pcm_ready), 0);
    rst = 1'b0;

    // Disabled: each ce_pdm toggles the output, ce_pcm never flags underrun.
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1, i == 2);
      check("idle_toggle", int'(pdm_data), (i % 2 == 0) ? 1 : 0);
      repeat (3) cyc();
    end
    check("idle_ready", int'(pcm_ready), 0);
    check("idle_underrun", int'(underrun), 0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    first_bits("first_bits");
    check("mid_i1", $signed(dut.r_i1), 49157);
    check("mid_i2", $signed(dut.r_i2), 65564);
    check("mid_buf_full", int'(dut.r_buf_full), 1);

    rst = 1'b1;
    cyc();
    check("rst_pdm", int'(pdm_data), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_i1", $signed(dut.r_i1), 0);
    check("rst_i2", $signed(dut.r_i2), 0);
    check("rst_cur", $signed(dut.r_cur), 0);
    check("rst_buf_full", int'(dut.r_buf_full), 0);
    rst       = 1'b0;
    enable    = 1'b0;
    pcm_valid = 1'b0;
    first_bits("replay_bits");

    // Density table with the feeder holding valid high.
    for (int r = 0; r < 5; r++) begin
      pcm_valid = 1'b1;
      pcm_dat   = rows[r].sample;
      run_strobes(rows[r].settle, ones);
      run_strobes(rows[r].n, ones);
      check_range($sformatf("density_row%0d", r), ones, rows[r].lo, rows[r].hi);
      if (rows[r].chk_i2) check($sformatf("clamp_i2_row%0d", r), $signed(dut.r_i2), rows[r].exp_i2);
    end

    // Disable clears loop state and the pending sample.
    enable    = 1'b0;
    pcm_valid = 1'b0;
    cyc();
    check("dis_i1", $signed(dut.r_i1), 0);
    check("dis_i2", $signed(dut.r_i2), 0);
    check("dis_cur", $signed(dut.r_cur), 0);
    check("dis_buf_full", int'(dut.r_buf_full), 0);
    check("dis_ready", int'(pcm_ready), 0);

    // Backpressure: one accept fills the buffer and drops ready.
    enable    = 1'b1;
    pcm_valid = 1'b1;
    pcm_dat   = 16'd100;
    #1;
    check("bp_ready_empty", int'(pcm_ready), 1);
    cyc();
    check("bp_ready_full", int'(pcm_ready), 0);
    pcm_dat = 16'd200;
    cyc();
    check("bp_ready_held", int'(pcm_ready), 0);
    check("bp_cur_before", $signed(dut.r_cur), 0);
    strobe(1'b0, 1'b1);
    check("bp_cur_loaded", $signed(dut.r_cur), 100);
    check("bp_ready_again", int'(pcm_ready), 1);

    // Accept together with ce_pcm on an empty buffer goes straight to cur.
    pcm_dat = 16'd300;
    strobe(1'b0, 1'b1);
    check("bypass_cur", $signed(dut.r_cur), 300);
    check("bypass_buf_full", int'(dut.r_buf_full), 0);
    check("bypass_underrun", int'(underrun), 0);

    // Starvation sets the sticky flag and holds cur; set beats clear.
    pcm_valid = 1'b0;
    strobe(1'b0, 1'b1);
    check("underrun_set", int'(underrun), 1);
    check("underrun_cur_held", $signed(dut.r_cur), 300);
    clear = 1'b1;
    strobe(1'b0, 1'b1);
    clear = 1'b0;
    check("underrun_set_wins", int'(underrun), 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("underrun_cleared", int'(underrun), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
